// File: rtl/ir_fetch.sv
// Instruction fetch unit: reads two memory words per instruction, assembles
// {opcode, ir_addr} and hands it to the controller with a valid/ready handshake.
module ir_fetch #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 13,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              mem_rd,
  output logic              inc_pc,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, HOLD} state_t;

  localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        wait_cnt;
  logic [2:0]        op_buf;
  logic [DATA_W-4:0] hi_buf;

  assign mem_rd   = (state == RD_HI) || (state == RD_LO);
  assign ir_valid = (state == HOLD);

  // The high word is staged and published together with the low word, so a
  // timed-out fetch leaves opcode/ir_addr at the last complete instruction.
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      inc_pc    <= 1'b0;
      fetch_err <= 1'b0;
      opcode    <= '0;
      ir_addr   <= '0;
      op_buf    <= '0;
      hi_buf    <= '0;
    end else begin
      inc_pc    <= 1'b0;
      fetch_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_en) begin
            state    <= RD_HI;
            wait_cnt <= '0;
          end
        end
        RD_HI: begin
          if (mem_ack) begin
            op_buf   <= mem_data[DATA_W-1:DATA_W-3];
            hi_buf   <= mem_data[DATA_W-4:0];
            inc_pc   <= 1'b1;
            wait_cnt <= '0;
            state    <= RD_LO;
          end else if (wait_cnt == WAIT_LIM) begin
            fetch_err <= 1'b1;
            wait_cnt  <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RD_LO: begin
          if (mem_ack) begin
            opcode   <= op_buf;
            ir_addr  <= {hi_buf, mem_data};
            inc_pc   <= 1'b1;
            wait_cnt <= '0;
            state    <= HOLD;
          end else if (wait_cnt == WAIT_LIM) begin
            fetch_err <= 1'b1;
            wait_cnt  <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            state    <= fetch_en ? RD_HI : IDLE;
            wait_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_fetch.sv
// Directed bench for ir_fetch: linear cycle-by-cycle stimulus with
// hand-computed expectations checked by immediate assertions.
module tb_ir_fetch;

  logic        clock = 1'b0;
  logic        rst, fetch_en, mem_ack, ir_ready;
  logic [7:0]  mem_data;
  logic        mem_rd, inc_pc, ir_valid, fetch_err;
  logic [2:0]  opcode;
  logic [12:0] ir_addr;

  int total = 0;
  int bad   = 0;
  int inc_cnt = 0;
  int err_cnt = 0;

  ir_fetch #(.DATA_W(8), .ADDR_W(13), .TIMEOUT(15)) dut (
    .clock(clock), .rst(rst), .fetch_en(fetch_en), .mem_data(mem_data),
    .mem_ack(mem_ack), .mem_rd(mem_rd), .inc_pc(inc_pc), .opcode(opcode),
    .ir_addr(ir_addr), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (inc_pc)    inc_cnt++;
    if (fetch_err) err_cnt++;
  end

  // Advance to the next cycle and settle just after the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; mem_ack = 1'b0; ir_ready = 1'b0; mem_data = 8'h00;
    tick();
    tick();
    chk("rst_mem_rd", 16'(mem_rd), 16'd0);
    chk("rst_inc_pc", 16'(inc_pc), 16'd0);
    chk("rst_valid", 16'(ir_valid), 16'd0);
    chk("rst_err", 16'(fetch_err), 16'd0);
    chk("rst_opcode", 16'(opcode), 16'd0);
    chk("rst_addr", 16'(ir_addr), 16'd0);

    // Zero-wait fetch of 0xA5, 0x3C
    rst = 1'b0; fetch_en = 1'b1;
    tick();                       // edge 0 samples fetch_en in IDLE
    inc_cnt = 0; err_cnt = 0;
    tick();                       // cycle 1: RD_HI
    chk("c1_mem_rd", 16'(mem_rd), 16'd1);
    chk("c1_valid", 16'(ir_valid), 16'd0);
    mem_ack = 1'b1; mem_data = 8'hA5;
    tick();                       // cycle 2: RD_LO
    chk("c2_mem_rd", 16'(mem_rd), 16'd1);
    chk("c2_inc_pc", 16'(inc_pc), 16'd1);
    chk("c2_valid", 16'(ir_valid), 16'd0);
    mem_data = 8'h3C;
    tick();                       // cycle 3: HOLD
    chk("c3_valid", 16'(ir_valid), 16'd1);
    chk("c3_inc_pc", 16'(inc_pc), 16'd1);
    chk("c3_mem_rd", 16'(mem_rd), 16'd0);
    chk("c3_opcode", 16'(opcode), 16'd5);
    chk("c3_addr", 16'(ir_addr), 16'h053C);
    mem_ack = 1'b0; fetch_en = 1'b0;
    tick();
    chk("c4_inc_cnt", 16'(inc_cnt), 16'd2);

    // HOLD with ir_ready low and spurious acks carrying 0xFF
    for (int i = 0; i < 10; i++) begin
      mem_ack = i[0]; mem_data = 8'hFF;
      tick();
      chk("hold_valid", 16'(ir_valid), 16'd1);
      chk("hold_mem_rd", 16'(mem_rd), 16'd0);
      chk("hold_inc_pc", 16'(inc_pc), 16'd0);
      chk("hold_opcode", 16'(opcode), 16'd5);
      chk("hold_addr", 16'(ir_addr), 16'h053C);
    end
    mem_ack = 1'b0; ir_ready = 1'b1;
    tick();                       // transfer, fetch_en low -> IDLE
    chk("xfer_valid", 16'(ir_valid), 16'd0);
    chk("xfer_mem_rd", 16'(mem_rd), 16'd0);
    chk("hold_inc_cnt", 16'(inc_cnt), 16'd2);

    // Back-to-back: 0x1F,0xFF then 0xE0,0x00
    fetch_en = 1'b1;
    tick();                       // RD_HI
    chk("b2b_rd1", 16'(mem_rd), 16'd1);
    mem_ack = 1'b1; mem_data = 8'h1F;
    tick();                       // RD_LO
    mem_data = 8'hFF;
    tick();                       // HOLD, accepted this cycle
    chk("b2b_valid1", 16'(ir_valid), 16'd1);
    chk("b2b_op1", 16'(opcode), 16'd0);
    chk("b2b_addr1", 16'(ir_addr), 16'h1FFF);
    mem_data = 8'hE0;             // ignored in HOLD, consumed in RD_HI
    tick();                       // RD_HI
    chk("b2b_drop", 16'(ir_valid), 16'd0);
    chk("b2b_rd2", 16'(mem_rd), 16'd1);
    tick();                       // RD_LO
    mem_data = 8'h00;
    tick();                       // HOLD, three cycles after the first
    chk("b2b_valid2", 16'(ir_valid), 16'd1);
    chk("b2b_op2", 16'(opcode), 16'd7);
    chk("b2b_addr2", 16'(ir_addr), 16'h0000);
    mem_ack = 1'b0; fetch_en = 1'b0;
    tick();                       // IDLE

    // Four wait cycles per byte: 0x6B, 0x21 -> ir_valid in cycle 11
    fetch_en = 1'b1; ir_ready = 1'b0; err_cnt = 0;
    tick();                       // cycle 1
    fetch_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("dly_hi_wait", 16'({mem_rd, ir_valid}), 16'b10);
      tick();
    end
    mem_ack = 1'b1; mem_data = 8'h6B;
    tick();                       // cycle 6
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("dly_lo_wait", 16'({mem_rd, ir_valid}), 16'b10);
      tick();
    end
    chk("dly_c10_valid", 16'(ir_valid), 16'd0);
    mem_ack = 1'b1; mem_data = 8'h21;
    tick();                       // cycle 11
    mem_ack = 1'b0;
    chk("dly_c11_valid", 16'(ir_valid), 16'd1);
    chk("dly_opcode", 16'(opcode), 16'd3);
    chk("dly_addr", 16'(ir_addr), 16'h0B21);
    chk("dly_no_err", 16'(err_cnt), 16'd0);
    ir_ready = 1'b1;
    tick();                       // IDLE

    // Timeout in RD_LO after high byte 0x42
    fetch_en = 1'b1; ir_ready = 1'b0;
    tick();                       // RD_HI
    inc_cnt = 0; err_cnt = 0; fetch_en = 1'b0;
    mem_ack = 1'b1; mem_data = 8'h42;
    tick();                       // RD_LO entry, cycle m
    mem_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("to_wait", 16'({mem_rd, fetch_err}), 16'b10);
      tick();
    end
    chk("to_err", 16'(fetch_err), 16'd1);
    chk("to_mem_rd", 16'(mem_rd), 16'd0);
    chk("to_valid", 16'(ir_valid), 16'd0);
    chk("to_opcode", 16'(opcode), 16'd3);
    chk("to_addr", 16'(ir_addr), 16'h0B21);
    tick();
    chk("to_err_pulse", 16'(fetch_err), 16'd0);
    chk("to_idle", 16'(mem_rd), 16'd0);
    chk("to_inc_cnt", 16'(inc_cnt), 16'd1);
    chk("to_err_cnt", 16'(err_cnt), 16'd1);

    // Ack on the last permitted wait cycle of the high byte is a success
    fetch_en = 1'b1; err_cnt = 0;
    tick();                       // RD_HI, cycle k
    fetch_en = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("edge_still_rd", 16'(mem_rd), 16'd1);
    mem_ack = 1'b1; mem_data = 8'hC0;
    tick();
    mem_data = 8'h01;
    tick();
    mem_ack = 1'b0;
    chk("edge_valid", 16'(ir_valid), 16'd1);
    chk("edge_opcode", 16'(opcode), 16'd6);
    chk("edge_addr", 16'(ir_addr), 16'h0001);
    chk("edge_no_err", 16'(err_cnt), 16'd0);
    ir_ready = 1'b1;
    tick();

    // Reset while in RD_LO after high byte captured
    fetch_en = 1'b1; ir_ready = 1'b0; inc_cnt = 0; err_cnt = 0;
    tick();                       // RD_HI
    mem_ack = 1'b1; mem_data = 8'h99;
    tick();                       // RD_LO
    chk("mid_inc_pc", 16'(inc_pc), 16'd1);
    rst = 1'b1; mem_ack = 1'b0; fetch_en = 1'b0;
    tick();
    chk("mid_rst_state", 16'({mem_rd, inc_pc, ir_valid, fetch_err}), 16'd0);
    chk("mid_rst_opcode", 16'(opcode), 16'd0);
    chk("mid_rst_addr", 16'(ir_addr), 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", 16'({mem_rd, ir_valid}), 16'd0);
    end
    chk("post_rst_inc", 16'(inc_cnt), 16'd1);
    chk("post_rst_err", 16'(err_cnt), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
